// File: rtl/axi_lite_reg_bridge.sv
// AXI4-Lite slave to single-beat register bus bridge.
// One outstanding transaction, alternating read/write priority, bounded register-side stall.
module axi_lite_reg_bridge #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              axi_awvalid_i,
    output logic              axi_awready_o,
    input  logic [ADDR_W-1:0] axi_awaddr_i,
    input  logic              axi_wvalid_i,
    output logic              axi_wready_o,
    input  logic [31:0]       axi_wdata_i,
    input  logic [3:0]        axi_wstrb_i,
    output logic              axi_bvalid_o,
    input  logic              axi_bready_i,
    output logic [1:0]        axi_bresp_o,

    input  logic              axi_arvalid_i,
    output logic              axi_arready_o,
    input  logic [ADDR_W-1:0] axi_araddr_i,
    output logic              axi_rvalid_o,
    input  logic              axi_rready_i,
    output logic [31:0]       axi_rdata_o,
    output logic [1:0]        axi_rresp_o,

    output logic              reg_en_o,
    output logic              reg_we_o,
    output logic [ADDR_W-1:0] reg_addr_o,
    output logic [31:0]       reg_wdata_o,
    input  logic              reg_ready_i,
    input  logic [31:0]       reg_rdata_i
);

    localparam logic [8:0]        LP_TIMEOUT = 9'(TIMEOUT);
    localparam logic              LP_TO_EN   = (TIMEOUT != 0);
    localparam logic [ADDR_W-1:0] LP_WMASK   = {{(ADDR_W-2){1'b1}}, 2'b00};
    localparam logic [1:0]        LP_OKAY    = 2'b00;
    localparam logic [1:0]        LP_SLVERR  = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_REQ,
        S_WR_RESP,
        S_RD_REQ,
        S_RD_CAP,
        S_RD_RESP
    } state_t;

    state_t            r_state;
    logic              r_prio_wr;
    logic [7:0]        r_cnt;
    logic              r_reg_en;
    logic              r_reg_we;
    logic [ADDR_W-1:0] r_reg_addr;
    logic [31:0]       r_reg_wdata;
    logic [31:0]       r_rdata;
    logic              r_bvalid;
    logic              r_rvalid;
    logic [1:0]        r_bresp;
    logic [1:0]        r_rresp;

    logic              w_idle;
    logic              w_wcand;
    logic              w_rcand;
    logic              w_grant_wr;
    logic              w_grant_rd;
    logic [8:0]        w_cnt_inc;
    logic              w_timeout;

    // Grants are decoded combinationally so a handshake completes in the IDLE cycle itself.
    assign w_idle     = (r_state == S_IDLE) && !rst_i;
    assign w_wcand    = axi_awvalid_i && axi_wvalid_i;
    assign w_rcand    = axi_arvalid_i;
    assign w_grant_wr = w_idle && w_wcand && (!w_rcand || r_prio_wr);
    assign w_grant_rd = w_idle && w_rcand && (!w_wcand || !r_prio_wr);

    // A ready in the same cycle the count hits TIMEOUT is still an accept.
    assign w_cnt_inc  = {1'b0, r_cnt} + 9'd1;
    assign w_timeout  = LP_TO_EN && !reg_ready_i && (w_cnt_inc == LP_TIMEOUT);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= S_IDLE;
            r_prio_wr   <= 1'b1;
            r_cnt       <= '0;
            r_reg_en    <= 1'b0;
            r_reg_we    <= 1'b0;
            r_reg_addr  <= '0;
            r_reg_wdata <= '0;
            r_rdata     <= '0;
            r_bvalid    <= 1'b0;
            r_rvalid    <= 1'b0;
            r_bresp     <= '0;
            r_rresp     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant_wr) begin
                        r_prio_wr   <= 1'b0;
                        r_reg_addr  <= axi_awaddr_i & LP_WMASK;
                        r_reg_wdata <= axi_wdata_i;
                        if (axi_wstrb_i != 4'hF) begin
                            r_bresp  <= LP_SLVERR;
                            r_bvalid <= 1'b1;
                            r_state  <= S_WR_RESP;
                        end else begin
                            r_reg_en <= 1'b1;
                            r_reg_we <= 1'b1;
                            r_cnt    <= '0;
                            r_state  <= S_WR_REQ;
                        end
                    end else if (w_grant_rd) begin
                        r_prio_wr  <= 1'b1;
                        r_reg_addr <= axi_araddr_i & LP_WMASK;
                        r_reg_en   <= 1'b1;
                        r_reg_we   <= 1'b0;
                        r_cnt      <= '0;
                        r_state    <= S_RD_REQ;
                    end
                end

                S_WR_REQ: begin
                    if (reg_ready_i || w_timeout) begin
                        r_reg_en <= 1'b0;
                        r_reg_we <= 1'b0;
                        r_bresp  <= reg_ready_i ? LP_OKAY : LP_SLVERR;
                        r_bvalid <= 1'b1;
                        r_state  <= S_WR_RESP;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end

                S_RD_REQ: begin
                    if (reg_ready_i) begin
                        r_reg_en <= 1'b0;
                        r_state  <= S_RD_CAP;
                    end else if (w_timeout) begin
                        r_reg_en <= 1'b0;
                        r_rdata  <= '0;
                        r_rresp  <= LP_SLVERR;
                        r_rvalid <= 1'b1;
                        r_state  <= S_RD_RESP;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end

                S_RD_CAP: begin
                    r_rdata  <= reg_rdata_i;
                    r_rresp  <= LP_OKAY;
                    r_rvalid <= 1'b1;
                    r_state  <= S_RD_RESP;
                end

                S_WR_RESP: begin
                    if (axi_bready_i) begin
                        r_bvalid <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                end

                S_RD_RESP: begin
                    if (axi_rready_i) begin
                        r_rvalid <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign axi_awready_o = w_grant_wr;
    assign axi_wready_o  = w_grant_wr;
    assign axi_arready_o = w_grant_rd;
    assign axi_bvalid_o  = r_bvalid;
    assign axi_bresp_o   = r_bresp;
    assign axi_rvalid_o  = r_rvalid;
    assign axi_rdata_o   = r_rdata;
    assign axi_rresp_o   = r_rresp;
    assign reg_en_o      = r_reg_en;
    assign reg_we_o      = r_reg_we;
    assign reg_addr_o    = r_reg_addr;
    assign reg_wdata_o   = r_reg_wdata;

endmodule

// File: tb/tb_axi_lite_reg_bridge.sv
// Bench for axi_lite_reg_bridge: vector table with response scoreboard,
// plus hand sequences for arbitration and mid-transaction reset.
module tb_axi_lite_reg_bridge;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        axi_awvalid_i, axi_awready_o;
    logic [31:0] axi_awaddr_i;
    logic        axi_wvalid_i, axi_wready_o;
    logic [31:0] axi_wdata_i;
    logic [3:0]  axi_wstrb_i;
    logic        axi_bvalid_o, axi_bready_i;
    logic [1:0]  axi_bresp_o;
    logic        axi_arvalid_i, axi_arready_o;
    logic [31:0] axi_araddr_i;
    logic        axi_rvalid_o, axi_rready_i;
    logic [31:0] axi_rdata_o;
    logic [1:0]  axi_rresp_o;
    logic        reg_en_o, reg_we_o;
    logic [31:0] reg_addr_o, reg_wdata_o;
    logic        reg_ready_i;
    logic [31:0] reg_rdata_i;

    axi_lite_reg_bridge #(.ADDR_W(32), .TIMEOUT(16)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .axi_awvalid_i(axi_awvalid_i), .axi_awready_o(axi_awready_o), .axi_awaddr_i(axi_awaddr_i),
        .axi_wvalid_i(axi_wvalid_i), .axi_wready_o(axi_wready_o),
        .axi_wdata_i(axi_wdata_i), .axi_wstrb_i(axi_wstrb_i),
        .axi_bvalid_o(axi_bvalid_o), .axi_bready_i(axi_bready_i), .axi_bresp_o(axi_bresp_o),
        .axi_arvalid_i(axi_arvalid_i), .axi_arready_o(axi_arready_o), .axi_araddr_i(axi_araddr_i),
        .axi_rvalid_o(axi_rvalid_o), .axi_rready_i(axi_rready_i),
        .axi_rdata_o(axi_rdata_o), .axi_rresp_o(axi_rresp_o),
        .reg_en_o(reg_en_o), .reg_we_o(reg_we_o), .reg_addr_o(reg_addr_o),
        .reg_wdata_o(reg_wdata_o), .reg_ready_i(reg_ready_i), .reg_rdata_i(reg_rdata_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] rdata;
        int          stall;     // register-side ready arrives on en cycle stall+1
        bit          hold;      // keep bready/rready low one extra cycle
        logic [1:0]  e_resp;
        logic [31:0] e_rdata;
        logic [31:0] e_raddr;
        int          e_lat;     // handshake cycle to response-valid cycle
        int          e_en;      // cycles reg_en_o is high
    } vec_t;

    typedef struct {
        logic [1:0]  resp;
        logic [31:0] rdata;
        int          lat;
        int          en;
    } exp_t;

    vec_t vecs[10];
    exp_t sb[$];
    int   n_checks = 0;
    int   n_errs   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic check_zero(input string pfx);
        check({pfx, "_ctrl"}, {axi_awready_o, axi_wready_o, axi_arready_o, axi_bvalid_o,
                               axi_rvalid_o, reg_en_o, reg_we_o, axi_bresp_o, axi_rresp_o}, 64'h0);
        check({pfx, "_addr"}, reg_addr_o, 64'h0);
        check({pfx, "_wdata"}, reg_wdata_o, 64'h0);
        check({pfx, "_rdata"}, axi_rdata_o, 64'h0);
    endtask

    task automatic run_txn(input vec_t v);
        exp_t e;
        int   k, en_cnt, lat;
        bit   acc_prev, got, granted, vld;
        e.resp = v.e_resp; e.rdata = v.e_rdata; e.lat = v.e_lat; e.en = v.e_en;
        sb.push_back(e);
        if (v.wr) begin
            axi_awvalid_i = 1'b1; axi_awaddr_i = v.addr;
            axi_wvalid_i = 1'b1; axi_wdata_i = v.data; axi_wstrb_i = v.strb;
        end else begin
            axi_arvalid_i = 1'b1; axi_araddr_i = v.addr;
        end
        #1;
        k = 0;
        granted = v.wr ? (axi_awready_o && axi_wready_o) : axi_arready_o;
        while (!granted && k < 10) begin
            tick();
            k++;
            granted = v.wr ? (axi_awready_o && axi_wready_o) : axi_arready_o;
        end
        check("grant", granted, 1);
        en_cnt = 0; acc_prev = 0; got = 0; lat = 0;
        reg_rdata_i = ~v.rdata;
        for (int c = 1; c <= 40 && !got; c++) begin
            tick();
            if (c == 1) begin
                axi_awvalid_i = 1'b0; axi_wvalid_i = 1'b0; axi_arvalid_i = 1'b0;
            end
            if (v.wr ? axi_bvalid_o : axi_rvalid_o) begin
                got = 1; lat = c;
            end else if (reg_en_o) begin
                en_cnt++;
                if (en_cnt == 1) begin
                    check("reg_addr", reg_addr_o, v.e_raddr);
                    check("reg_we", reg_we_o, v.wr);
                    if (v.wr) check("reg_wdata", reg_wdata_o, v.data);
                end
                reg_ready_i = (en_cnt > v.stall);
                acc_prev    = reg_ready_i;
                reg_rdata_i = ~v.rdata;
            end else begin
                reg_ready_i = 1'b0;
                reg_rdata_i = acc_prev ? v.rdata : ~v.rdata;
                acc_prev    = 1'b0;
            end
        end
        reg_ready_i = 1'b0;
        check("resp_seen", got, 1);
        e = sb.pop_front();
        if (got) begin
            check("latency", lat, e.lat);
            check("en_cycles", en_cnt, e.en);
            check("resp", v.wr ? axi_bresp_o : axi_rresp_o, e.resp);
            if (!v.wr) check("rdata", axi_rdata_o, e.rdata);
            if (v.hold) begin
                tick();
                vld = v.wr ? axi_bvalid_o : axi_rvalid_o;
                check("hold_valid", vld, 1);
                check("hold_resp", v.wr ? axi_bresp_o : axi_rresp_o, e.resp);
                if (!v.wr) check("hold_rdata", axi_rdata_o, e.rdata);
            end
            if (v.wr) axi_bready_i = 1'b1; else axi_rready_i = 1'b1;
            tick();
            vld = v.wr ? axi_bvalid_o : axi_rvalid_o;
            check("valid_drop", vld, 0);
            axi_bready_i = 1'b0; axi_rready_i = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, errors=%0d", n_errs);
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        vecs[0] = '{1, 32'h0400_4000, 32'hDEAD_BEEF, 4'hF, 32'h0,         0,   0, 2'b00, 32'h0,         32'h0400_4000, 2,  1};
        vecs[1] = '{0, 32'h0400_1003, 32'h0,         4'h0, 32'h1234_5678, 0,   0, 2'b00, 32'h1234_5678, 32'h0400_1000, 3,  1};
        vecs[2] = '{1, 32'h0000_0010, 32'hA5A5_0F0F, 4'h3, 32'h0,         0,   1, 2'b10, 32'h0,         32'h0,         1,  0};
        vecs[3] = '{0, 32'h0400_2008, 32'h0,         4'h0, 32'h8765_4321, 3,   1, 2'b00, 32'h8765_4321, 32'h0400_2008, 6,  4};
        vecs[4] = '{1, 32'h0400_300E, 32'h0BAD_F00D, 4'hF, 32'h0,         2,   0, 2'b00, 32'h0,         32'h0400_300C, 4,  3};
        vecs[5] = '{0, 32'h0400_0004, 32'h0,         4'h0, 32'h1111_2222, 255, 1, 2'b10, 32'h0,         32'h0400_0004, 17, 16};
        vecs[6] = '{0, 32'h0400_0009, 32'h0,         4'h0, 32'h3333_4444, 15,  0, 2'b00, 32'h3333_4444, 32'h0400_0008, 18, 16};
        vecs[7] = '{1, 32'h0400_0FFC, 32'hFEED_FACE, 4'hF, 32'h0,         255, 0, 2'b10, 32'h0,         32'h0400_0FFC, 17, 16};
        vecs[8] = '{1, 32'h0400_0020, 32'h0000_0001, 4'hE, 32'h0,         0,   0, 2'b10, 32'h0,         32'h0,         1,  0};
        vecs[9] = '{1, 32'h0400_0024, 32'h2468_ACE0, 4'hF, 32'h0,         1,   0, 2'b00, 32'h0,         32'h0400_0024, 3,  2};

        rst_i = 1'b1;
        axi_awvalid_i = 0; axi_awaddr_i = '0; axi_wvalid_i = 0; axi_wdata_i = '0; axi_wstrb_i = '0;
        axi_bready_i = 0; axi_arvalid_i = 0; axi_araddr_i = '0; axi_rready_i = 0;
        reg_ready_i = 0; reg_rdata_i = '0;
        tick(); tick();
        check_zero("reset");
        rst_i = 1'b0;
        tick();
        check_zero("post_reset");

        for (int i = 0; i < 10; i++) run_txn(vecs[i]);

        // Contention: write first after reset-like priority, then the held read.
        tick();
        rst_i = 1'b1; tick(); rst_i = 1'b0; tick();
        axi_awvalid_i = 1; axi_awaddr_i = 32'h0400_0040; axi_wvalid_i = 1;
        axi_wdata_i = 32'h0F0F_0F0F; axi_wstrb_i = 4'hF;
        axi_arvalid_i = 1; axi_araddr_i = 32'h0400_0080;
        reg_ready_i = 1; axi_bready_i = 1; axi_rready_i = 1;
        #1;
        check("arb1_wgrant", {axi_awready_o, axi_wready_o, axi_arready_o}, 3'b110);
        tick();
        axi_awvalid_i = 0; axi_wvalid_i = 0;
        check("arb1_wr_en", {reg_en_o, reg_we_o}, 2'b11);
        tick();
        check("arb1_bvalid", axi_bvalid_o, 1);
        tick();
        check("arb1_rgrant", {axi_awready_o, axi_arready_o}, 2'b01);
        tick();
        axi_arvalid_i = 0;
        check("arb1_rd_en", {reg_en_o, reg_we_o}, 2'b10);
        tick(); tick();
        check("arb1_rvalid", axi_rvalid_o, 1);
        tick();
        axi_awvalid_i = 1; axi_wvalid_i = 1;
        #1;
        check("lone_wgrant", axi_awready_o, 1);
        tick();
        axi_awvalid_i = 0; axi_wvalid_i = 0;
        tick(); tick();
        axi_awvalid_i = 1; axi_wvalid_i = 1; axi_arvalid_i = 1;
        #1;
        check("arb2_rgrant", {axi_awready_o, axi_wready_o, axi_arready_o}, 3'b001);
        tick();
        axi_awvalid_i = 0; axi_wvalid_i = 0; axi_arvalid_i = 0;
        check("arb2_rd_en", {reg_en_o, reg_we_o}, 2'b10);
        tick(); tick(); tick(); tick();
        reg_ready_i = 0; axi_bready_i = 0; axi_rready_i = 0;

        // Reset while in WR_REQ.
        axi_awvalid_i = 1; axi_awaddr_i = 32'h0000_0104; axi_wvalid_i = 1;
        axi_wdata_i = 32'h55AA_55AA; axi_wstrb_i = 4'hF;
        #1;
        check("rstw_grant", axi_awready_o, 1);
        tick();
        axi_awvalid_i = 0; axi_wvalid_i = 0;
        check("rstw_in_req", reg_en_o, 1);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check_zero("rstw");
        axi_bready_i = 1; seen = 0;
        for (int i = 0; i < 4; i++) begin tick(); seen |= axi_bvalid_o | reg_en_o; end
        check("rstw_no_resp", seen, 0);
        axi_bready_i = 0;
        run_txn(vecs[0]);

        // Reset while in RD_RESP with rready low.
        axi_arvalid_i = 1; axi_araddr_i = 32'h0000_0208;
        reg_ready_i = 1; reg_rdata_i = 32'hCAFE_F00D;
        #1;
        check("rstr_grant", axi_arready_o, 1);
        tick();
        axi_arvalid_i = 0;
        tick(); tick();
        check("rstr_rvalid", {axi_rvalid_o, axi_rdata_o}, {1'b1, 32'hCAFE_F00D});
        tick();
        check("rstr_rvalid_held", {axi_rvalid_o, axi_rdata_o}, {1'b1, 32'hCAFE_F00D});
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0; reg_ready_i = 0;
        check_zero("rstr");
        axi_rready_i = 1; seen = 0;
        for (int i = 0; i < 4; i++) begin tick(); seen |= axi_rvalid_o | reg_en_o; end
        check("rstr_no_resp", seen, 0);
        axi_rready_i = 0;
        run_txn(vecs[1]);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
